// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares a single-port frame-buffer RAM between the VGA display fetch, a
// pixel writer (valid/ready) and a built-in clear sequencer.
//
// The display fetch owns the cycle right after each pix_tick whenever DE is
// high. Every other cycle is free and goes either to the writer (IDLE) or to
// the clear sequencer (CLEAR).
//
// Ports
//   clk, reset            system clock, synchronous active-low reset
//   pix_tick, de_in,      VGA pixel strobe, display enable and coordinates
//   x_in, y_in
//   wr_valid/addr/data    writer request
//   wr_ready              combinational grant
//   wr_err                pulse: a transferred write was out of range
//   clr_start, clr_color  start a clear with the given fill colour
//   clr_busy, clr_done    clear running / one-cycle completion pulse
//   mem_*                 RAM port (read data one cycle after a read)
//   pix_rgb, pix_de       registered pixel and DE to the output stage
module vga_fb_arbiter #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned SCALE_SHIFT = 3,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned ADDR_W      = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_tick,
  input  logic              de_in,
  input  logic [9:0]        x_in,
  input  logic [9:0]        y_in,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_err,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_rgb,
  output logic              pix_de
);

  localparam int unsigned       BUF_W     = H_RES >> SCALE_SHIFT;
  localparam int unsigned       BUF_H     = V_RES >> SCALE_SHIFT;
  localparam int unsigned       DEPTH     = BUF_W * BUF_H;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q;
  logic              slot_q;
  logic              rd_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [DATA_W-1:0] clr_color_q;
  logic              wr_err_q;
  logic              clr_busy_q;
  logic              clr_done_q;
  logic [DATA_W-1:0] pix_rgb_q;
  logic              pix_de_q;

  logic              disp_rd_s;
  logic              free_s;
  logic              xfer_s;
  logic              addr_ok_s;
  logic              clr_wr_s;
  logic [ADDR_W-1:0] disp_addr_s;
  logic [ADDR_W-1:0] clr_addr_d;

  // Arbitration: the display read wins its slot; nothing is granted in reset.
  assign disp_rd_s = reset & slot_q & de_in;
  assign free_s    = reset & ~disp_rd_s;
  assign wr_ready  = free_s & (state_q == ST_IDLE);
  assign xfer_s    = wr_valid & wr_ready;
  assign addr_ok_s = ({1'b0, wr_addr} < DEPTH_X);
  assign clr_wr_s  = free_s & (state_q == ST_CLEAR);
  assign clr_addr_d = clr_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Buffer address computed at 32 bits, then truncated to the RAM width so
  // out-of-range coordinates wrap instead of overflowing mid-expression.
  assign disp_addr_s = ADDR_W'(((32'(y_in) >> SCALE_SHIFT) * BUF_W)
                               + (32'(x_in) >> SCALE_SHIFT));

  // RAM port mux: display read, else clear write, else in-range writer write.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (disp_rd_s) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr_s;
    end else if (clr_wr_s) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = clr_addr_q;
      mem_wdata = clr_color_q;
    end else if (xfer_s && addr_ok_s) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Display pipeline: slot flag, read-capture flag and the output pixel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_q    <= 1'b0;
      rd_q      <= 1'b0;
      pix_rgb_q <= {DATA_W{1'b0}};
      pix_de_q  <= 1'b0;
    end else begin
      slot_q <= pix_tick;
      rd_q   <= disp_rd_s;
      if (rd_q) begin
        pix_rgb_q <= mem_rdata;
        pix_de_q  <= 1'b1;
      end else if (slot_q && !de_in) begin
        pix_rgb_q <= {DATA_W{1'b0}};
        pix_de_q  <= 1'b0;
      end else begin
        pix_rgb_q <= pix_rgb_q;
        pix_de_q  <= pix_de_q;
      end
    end
  end

  // Out-of-range writes are accepted and dropped; flag them one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= xfer_s & ~addr_ok_s;
    end
  end

  // Clear sequencer: walks 0..DEPTH-1 on free cycles, stalling on reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      clr_addr_q  <= {ADDR_W{1'b0}};
      clr_color_q <= {DATA_W{1'b0}};
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clr_start) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= {ADDR_W{1'b0}};
            clr_color_q <= clr_color;
            clr_busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (clr_wr_s) begin
            if (clr_addr_q == LAST_ADDR) begin
              state_q    <= ST_IDLE;
              clr_busy_q <= 1'b0;
              clr_done_q <= 1'b1;
            end else begin
              clr_addr_q <= clr_addr_d;
            end
          end else begin
            clr_addr_q <= clr_addr_q;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_err   = wr_err_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;
  assign pix_rgb  = pix_rgb_q;
  assign pix_de   = pix_de_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: models the RAM, drives directed and random
// traffic and checks every cycle against a behavioural reference model.
module tb_vga_fb_arbiter;

  localparam int DEPTH = 4800;
  localparam int BUF_W = 80;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_tick, de_in;
  logic [9:0]  x_in, y_in;
  logic        wr_valid;
  logic [12:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready, wr_err;
  logic        clr_start;
  logic [11:0] clr_color;
  logic        clr_busy, clr_done;
  logic        mem_en, mem_we;
  logic [12:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [11:0] pix_rgb;
  logic        pix_de;

  vga_fb_arbiter dut (
    .clk(clk), .reset(rst_n), .pix_tick(pix_tick), .de_in(de_in),
    .x_in(x_in), .y_in(y_in), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
    .clr_done(clr_done), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_rgb(pix_rgb), .pix_de(pix_de)
  );

  always #5 clk = ~clk;

  // Bench RAM: synchronous single port, zeroed on the first edge.
  logic [11:0] ram [0:8191];
  bit          ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 8192; i++) ram[i] <= 12'h000;
      mem_rdata     <= 12'h000;
      ram_init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [11:0] mdl_ram [0:8191];
  bit          m_tick_q, m_rd_q, m_clr;
  int          m_ptr;
  logic [11:0] m_col, m_rd_val;
  logic [11:0] e_pix;
  bit          e_de, e_err, e_busy, e_done;
  int          rd_cnt, done_cnt, clr_wr_cnt;
  bit          last_hs;
  logic [11:0] last_hs_data;

  // Stimulus state for the video timing.
  int tick_per = 0;
  int tick_cnt = 0;
  int vid_mode = 0;

  task automatic model_step();
    bit rd, ex_en, ex_we, ex_rdy;
    int ex_addr;
    logic [11:0] ex_wd;
    check_eq("pix_rgb",  32'(pix_rgb),  32'(e_pix));
    check_eq("pix_de",   32'(pix_de),   32'(e_de));
    check_eq("wr_err",   32'(wr_err),   32'(e_err));
    check_eq("clr_busy", 32'(clr_busy), 32'(e_busy));
    check_eq("clr_done", 32'(clr_done), 32'(e_done));
    if (clr_done) done_cnt++;
    if (mem_en && mem_we && clr_busy) clr_wr_cnt++;
    last_hs      = wr_valid && wr_ready;
    last_hs_data = wr_data;
    rd = 1'b0; ex_en = 1'b0; ex_we = 1'b0; ex_rdy = 1'b0; ex_addr = 0; ex_wd = 12'h000;
    if (rst_n) begin
      rd = m_tick_q && de_in;
      if (rd) begin
        ex_en   = 1'b1;
        ex_addr = ((int'(y_in) / 8) * BUF_W + int'(x_in) / 8) % 8192;
      end else if (m_clr) begin
        ex_en = 1'b1; ex_we = 1'b1; ex_addr = m_ptr; ex_wd = m_col;
      end else begin
        ex_rdy = 1'b1;
        if (wr_valid && int'(wr_addr) < DEPTH) begin
          ex_en = 1'b1; ex_we = 1'b1; ex_addr = int'(wr_addr); ex_wd = wr_data;
        end
      end
    end
    check_eq("wr_ready", 32'(wr_ready), 32'(ex_rdy));
    check_eq("mem_en",   32'(mem_en),   32'(ex_en));
    check_eq("mem_we",   32'(mem_we),   32'(ex_we));
    if (ex_en) check_eq("mem_addr", 32'(mem_addr), ex_addr);
    if (ex_we) check_eq("mem_wdata", 32'(mem_wdata), 32'(ex_wd));
    // Advance the model to the state after this edge.
    if (!rst_n) begin
      m_tick_q = 1'b0; m_rd_q = 1'b0; m_clr = 1'b0; m_ptr = 0; m_col = 12'h000;
      e_pix = 12'h000; e_de = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      if (m_rd_q) begin
        e_pix = m_rd_val; e_de = 1'b1;
      end else if (m_tick_q && !de_in) begin
        e_pix = 12'h000; e_de = 1'b0;
      end
      e_err  = ex_rdy && wr_valid && int'(wr_addr) >= DEPTH;
      e_done = 1'b0;
      if (!m_clr) begin
        if (clr_start) begin
          m_clr = 1'b1; m_ptr = 0; m_col = clr_color; e_busy = 1'b1;
        end
      end else if (!rd) begin
        if (m_ptr == DEPTH - 1) begin
          m_clr = 1'b0; e_busy = 1'b0; e_done = 1'b1;
        end else begin
          m_ptr++;
        end
      end
      if (rd) begin
        m_rd_val = mdl_ram[ex_addr];
        rd_cnt++;
      end
      if (ex_en && ex_we) mdl_ram[ex_addr] = ex_wd;
      m_rd_q   = rd;
      m_tick_q = pix_tick;
    end
  endtask

  task automatic video();
    if (tick_per != 0) begin
      tick_cnt++;
      if (tick_cnt >= tick_per) begin
        tick_cnt = 0;
        pix_tick = 1'b1;
        if (vid_mode == 1) begin
          de_in    = ($urandom_range(0, 7) != 0);
          tick_per = $urandom_range(3, 6);
        end else begin
          de_in = 1'b1;
        end
        if ($urandom_range(0, 15) == 0) begin
          x_in = 10'($urandom_range(0, 1023));
          y_in = 10'($urandom_range(0, 1023));
        end else begin
          x_in = 10'($urandom_range(0, 639));
          y_in = 10'($urandom_range(0, 479));
        end
      end else begin
        pix_tick = 1'b0;
      end
    end
  endtask

  task automatic run_cycle();
    video();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Runs until the clear finishes (busy drops) or the budget expires.
  task automatic run_clear(input int budget, input bit restart_mid);
    bit fin = 1'b0;
    for (int c = 0; c < budget && !fin; c++) begin
      wr_valid  = 1'($urandom_range(0, 1));
      wr_addr   = 13'($urandom_range(0, DEPTH + 5));
      wr_data   = 12'($urandom);
      clr_start = restart_mid && (c == 100);
      clr_color = 12'hF00;
      run_cycle();
      if (!clr_busy) fin = 1'b1;
    end
    clr_start = 1'b0;
    wr_valid  = 1'b0;
    check_eq("clr_finished", 32'(fin), 32'd1);
    run_cycle();
  endtask

  task automatic count_ram_not(input logic [11:0] col, output int bad);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== col) bad++;
  endtask

  initial begin
    logic [11:0] arb_q[$];
    int xfers, d0, bad;
    for (int i = 0; i < 8192; i++) mdl_ram[i] = 12'h000;
    m_tick_q = 1'b0; m_rd_q = 1'b0; m_clr = 1'b0; m_ptr = 0;
    m_col = 12'h000; m_rd_val = 12'h000;
    e_pix = 12'h000; e_de = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    rd_cnt = 0; done_cnt = 0; clr_wr_cnt = 0;
    rst_n = 1'b0; pix_tick = 1'b0; de_in = 1'b0; x_in = 10'd0; y_in = 10'd0;
    wr_valid = 1'b1; wr_addr = 13'd5; wr_data = 12'h123;
    clr_start = 1'b0; clr_color = 12'h000;
    @(posedge clk);
    #1;

    // Reset held with a pending write: everything quiet, no grant.
    repeat (3) run_cycle();
    rst_n = 1'b1;
    wr_valid = 1'b0;
    run_cycle();

    // Preload and display fetch of buffer address 81.
    wr_valid = 1'b1; wr_addr = 13'd81; wr_data = 12'hABC;
    run_cycle();
    wr_valid = 1'b0;
    de_in = 1'b1; x_in = 10'd8; y_in = 10'd8;
    pix_tick = 1'b1;
    run_cycle();
    pix_tick = 1'b0;
    repeat (3) run_cycle();
    check_eq("disp_pix", 32'(pix_rgb), 32'h00000ABC);
    check_eq("disp_de",  32'(pix_de),  32'd1);
    de_in = 1'b0;
    pix_tick = 1'b1;
    run_cycle();
    pix_tick = 1'b0;
    repeat (3) run_cycle();
    check_eq("blank_pix", 32'(pix_rgb), 32'd0);
    check_eq("blank_de",  32'(pix_de),  32'd0);

    // Arbitration: writer held valid against ticks every 4 cycles at DE=1.
    tick_per = 4; tick_cnt = 0; vid_mode = 2;
    wr_valid = 1'b1; wr_addr = 13'd100; wr_data = 12'($urandom);
    rd_cnt = 0; xfers = 0;
    for (int c = 0; c < 41; c++) begin
      run_cycle();
      if (last_hs) begin
        arb_q.push_back(last_hs_data);
        xfers++;
        wr_addr = wr_addr + 13'd1;
      end
      wr_data = 12'($urandom);
    end
    wr_valid = 1'b0;
    check_eq("arb_reads", 32'(rd_cnt), 32'd10);
    check_eq("arb_xfers", 32'(xfers), 32'd31);
    for (int i = 0; i < arb_q.size(); i++)
      check_eq("arb_data", 32'(ram[100 + i]), 32'(arb_q[i]));

    // Out-of-range and last-valid writer addresses.
    tick_per = 0; pix_tick = 1'b0;
    wr_valid = 1'b1; wr_addr = 13'd4800; wr_data = 12'h123;
    run_cycle();
    wr_valid = 1'b0;
    check_eq("bad_err", 32'(wr_err), 32'd1);
    wr_valid = 1'b1; wr_addr = 13'd4799; wr_data = 12'h5A5;
    run_cycle();
    wr_valid = 1'b0;
    check_eq("last_err", 32'(wr_err), 32'd0);
    check_eq("last_wr",  32'(ram[4799]), 32'h000005A5);

    // Full clear at DE=1 with a spurious restart mid-way.
    tick_per = 4; tick_cnt = 0; vid_mode = 2;
    d0 = done_cnt; clr_wr_cnt = 0;
    clr_color = 12'h00F; clr_start = 1'b1;
    run_cycle();
    clr_start = 1'b0;
    run_clear(8000, 1'b1);
    check_eq("clr_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("clr_wr_cnt",   32'(clr_wr_cnt), 32'd4800);
    count_ram_not(12'h00F, bad);
    check_eq("clr_image", 32'(bad), 32'd0);

    // Reset in the middle of a clear, then a fresh clear from address 0.
    d0 = done_cnt;
    clr_color = 12'h0F0; clr_start = 1'b1;
    run_cycle();
    clr_start = 1'b0;
    for (int c = 0; c < 4000 && m_ptr < 2000; c++) run_cycle();
    check_eq("mid_ptr", 32'(m_ptr), 32'd2000);
    rst_n = 1'b0;
    repeat (2) run_cycle();
    check_eq("abort_busy", 32'(clr_busy), 32'd0);
    rst_n = 1'b1;
    repeat (4) run_cycle();
    check_eq("abort_nodone", 32'(done_cnt - d0), 32'd0);
    clr_wr_cnt = 0;
    clr_color = 12'h333; clr_start = 1'b1;
    run_cycle();
    clr_start = 1'b0;
    run_clear(8000, 1'b0);
    check_eq("reclr_done", 32'(done_cnt - d0), 32'd1);
    check_eq("reclr_wr_cnt", 32'(clr_wr_cnt), 32'd4800);
    count_ram_not(12'h333, bad);
    check_eq("reclr_image", 32'(bad), 32'd0);

    // Random traffic with jittered ticks and occasional clears.
    vid_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      wr_valid  = ($urandom_range(0, 3) != 0);
      wr_addr   = 13'($urandom_range(0, DEPTH + 20));
      wr_data   = 12'($urandom);
      clr_start = ($urandom_range(0, 1499) == 0);
      clr_color = 12'($urandom);
      run_cycle();
    end
    clr_start = 1'b0;
    wr_valid  = 1'b0;
    bad = 0;
    for (int i = 0; i < 8192; i++) if (ram[i] !== mdl_ram[i]) bad++;
    check_eq("ram_image", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
